// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared encodings for the fetch stage
// Purpose: next-PC select codes, bubble instruction, reset vector and the
//          address-map nibbles used by the fetch stage region decode.
// Ports:   none (package).
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    PC_SEL_PLUS4  = 2'b00,
    PC_SEL_BRANCH = 2'b01,
    PC_SEL_JUMP   = 2'b10,
    PC_SEL_RSVD   = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    REGION_BIOS = 2'b00,
    REGION_IMEM = 2'b01,
    REGION_NONE = 2'b10
  } region_e;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h4000_0000;

  localparam logic [3:0] NIB_BIOS  = 4'h4;
  localparam logic [3:0] NIB_IMEM0 = 4'h1;
  localparam logic [3:0] NIB_IMEM1 = 4'h2;

  function automatic region_e region_of(input logic [3:0] nib);
    case (nib)
      NIB_BIOS:             return REGION_BIOS;
      NIB_IMEM0, NIB_IMEM1: return REGION_IMEM;
      default:              return REGION_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fetch_unit_pc_next_mux.sv
// rtl/fetch_unit_pc_next_mux.sv - prioritised next-PC select with word alignment
// Purpose: picks the next fetch address (reset > stall > branch > jump > pc+4)
//          and clears the two low bits so memories always see word addresses.
// Ports:   rst, stall        - priority overrides
//          pc_sel            - redirect select from decode
//          pc_q              - current PC
//          branch_tgt, jump_tgt - redirect targets
//          pc_next           - aligned next PC
module fetch_unit_pc_next_mux
  import fetch_unit_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            rst,
  input  logic            stall,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] pc_q,
  input  logic [XLEN-1:0] branch_tgt,
  input  logic [XLEN-1:0] jump_tgt,
  output logic [XLEN-1:0] pc_next
);

  logic [XLEN-1:0] pc_raw;
  pc_sel_e         sel;

  always_comb begin
    sel    = pc_sel_e'(pc_sel);
    pc_raw = pc_q + XLEN'(4);
    if (rst) begin
      pc_raw = RESET_PC;
    end else if (stall) begin
      // decode re-presents its select after the stall, so ignore it here
      pc_raw = pc_q;
    end else begin
      case (sel)
        PC_SEL_BRANCH: pc_raw = branch_tgt;
        PC_SEL_JUMP:   pc_raw = jump_tgt;
        default:       pc_raw = pc_q + XLEN'(4);
      endcase
    end
    pc_next = {pc_raw[XLEN-1:2], 2'b00};
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch stage: PC, memory addressing, squash and fetch count
// Purpose: owns the PC, drives the synchronous BIOS/IMEM read ports with the
//          next PC so the returned word lines up with pcF, squashes wrong-path
//          and unmapped fetches to a NOP, and counts delivered instructions.
// Ports:   clk, rst (sync, active-high)
//          stallF, pc_selD, branch_tgtD, jump_tgtD - control from decode
//          bios_addr/bios_dout, imem_addr/imem_dout - instruction memories
//          pcF, pc_plus4F, instrF                   - to the F/D register
//          fetch_fault                              - pcF unmapped
//          fetch_cnt                                - delivered instruction count
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter int              BIOS_AW   = 12,
  parameter int              IMEM_AW   = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallF,
  input  logic [1:0]         pc_selD,
  input  logic [XLEN-1:0]    branch_tgtD,
  input  logic [XLEN-1:0]    jump_tgtD,
  output logic [BIOS_AW-1:0] bios_addr,
  input  logic [XLEN-1:0]    bios_dout,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_dout,
  output logic [XLEN-1:0]    pcF,
  output logic [XLEN-1:0]    pc_plus4F,
  output logic [XLEN-1:0]    instrF,
  output logic               fetch_fault,
  output logic [31:0]        fetch_cnt
);

  logic [XLEN-1:0] pc_q, pc_d, pc_next;
  logic [31:0]     fetch_cnt_q, fetch_cnt_d;
  region_e         region;
  logic            unmapped;
  logic            redirect;
  logic            squash;

  fetch_unit_pc_next_mux #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_next_mux (
    .rst        (rst),
    .stall      (stallF),
    .pc_sel     (pc_selD),
    .pc_q       (pc_q),
    .branch_tgt (branch_tgtD),
    .jump_tgt   (jump_tgtD),
    .pc_next    (pc_next)
  );

  // Addressing with pc_next makes the read data land in the cycle pc_q holds
  // that address, so fetch needs no bubble; a stall re-reads the same word.
  assign bios_addr = pc_next[BIOS_AW+1:2];
  assign imem_addr = pc_next[IMEM_AW+1:2];

  always_comb begin
    region   = region_of(pc_q[XLEN-1:XLEN-4]);
    unmapped = (region == REGION_NONE);
    redirect = !stallF && ((pc_selD == PC_SEL_BRANCH) || (pc_selD == PC_SEL_JUMP));
    squash   = rst || unmapped || redirect;

    instrF = NOP_INSTR;
    if (!squash) begin
      case (region)
        REGION_BIOS: instrF = bios_dout;
        REGION_IMEM: instrF = imem_dout;
        default:     instrF = NOP_INSTR;
      endcase
    end

    pc_d = pc_next;

    fetch_cnt_d = fetch_cnt_q;
    if (rst) begin
      fetch_cnt_d = 32'd0;
    end else if (!stallF && !squash) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    pc_q        <= pc_d;
    fetch_cnt_q <= fetch_cnt_d;
  end

  assign pcF         = pc_q;
  assign pc_plus4F   = pc_q + XLEN'(4);
  assign fetch_fault = unmapped && !rst;
  assign fetch_cnt   = fetch_cnt_q;

endmodule
